// File: rtl/guess_number_core.sv
// Clocked core of the two-player number-guessing game: edge-detected keypad entry of a
// secret, then guesses compared numerically with win/lose tracking.
module guess_number_core #(
   parameter int NUM_KEYS   = 4,
   parameter int MAX_DIGITS = 5,
   parameter int MAX_TRIES  = 4,
   localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                enter,
   output logic                win,
   output logic                lose,
   output logic                equal,
   output logic                bigger,
   output logic                smaller,
   output logic [NUM_KEYS-1:0] nums,
   output logic [CNT_W-1:0]    digit_cnt,
   output logic [3:0]          tries_left,
   output logic                guess_phase
);

   typedef enum logic [1:0] {SECRET, GUESS, WON, LOST} state_t;

   state_t state, state_next;

   logic [NUM_KEYS-1:0] keys_q;
   logic                enter_q;
   logic [NUM_KEYS-1:0] key_press;
   logic                enter_press;
   logic                single_key;
   logic [3:0]          key_value;

   logic [3:0]          secret_buf [MAX_DIGITS];
   logic [3:0]          guess_buf  [MAX_DIGITS];
   logic [CNT_W-1:0]    secret_len;
   logic [CNT_W-1:0]    digit_cnt_q;
   logic [3:0]          tries_q;
   logic [NUM_KEYS-1:0] nums_q;
   logic                equal_q;
   logic                bigger_q;
   logic                smaller_q;

   logic                enter_ok;
   logic                digit_ok;
   logic                cmp_gt;
   logic                cmp_lt;
   logic                decided;

   assign key_press   = keys & ~keys_q;
   assign enter_press = enter & ~enter_q;
   assign single_key  = (key_press != '0) &&
                        ((key_press & (key_press - NUM_KEYS'(1))) == '0);
   assign enter_ok    = enter_press && (digit_cnt_q != '0);
   assign digit_ok    = ((state == SECRET) || (state == GUESS)) && single_key &&
                        !enter_press && (digit_cnt_q < CNT_W'(MAX_DIGITS));

   always_comb begin
      key_value = 4'd0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (key_press[i]) begin
            key_value = 4'(i + 1);
         end
      end
   end

   // Digits are nonzero, so a longer number is always larger; for equal lengths the
   // first differing digit from the MSD decides. Unused buffer slots are kept at zero.
   always_comb begin
      cmp_gt  = 1'b0;
      cmp_lt  = 1'b0;
      decided = 1'b0;
      if (digit_cnt_q > secret_len) begin
         cmp_gt = 1'b1;
      end else if (digit_cnt_q < secret_len) begin
         cmp_lt = 1'b1;
      end else begin
         for (int i = 0; i < MAX_DIGITS; i++) begin
            if (!decided && (guess_buf[i] != secret_buf[i])) begin
               decided = 1'b1;
               cmp_gt  = guess_buf[i] > secret_buf[i];
               cmp_lt  = guess_buf[i] < secret_buf[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SECRET;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SECRET: begin
            if (enter_ok) begin
               state_next = GUESS;
            end
         end
         GUESS: begin
            if (enter_ok) begin
               if (!cmp_gt && !cmp_lt) begin
                  state_next = WON;
               end else if (tries_q == 4'd1) begin
                  state_next = LOST;
               end
            end
         end
         default: begin
            if (enter_press) begin
               state_next = SECRET;
            end
         end
      endcase
   end

   always_comb begin
      win         = (state == WON);
      lose        = (state == LOST);
      guess_phase = (state != SECRET);
      equal       = equal_q;
      bigger      = bigger_q;
      smaller     = smaller_q;
      nums        = nums_q;
      digit_cnt   = digit_cnt_q;
      tries_left  = tries_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keys_q      <= '0;
         enter_q     <= 1'b0;
         secret_len  <= '0;
         digit_cnt_q <= '0;
         tries_q     <= 4'(MAX_TRIES);
         nums_q      <= '0;
         equal_q     <= 1'b0;
         bigger_q    <= 1'b0;
         smaller_q   <= 1'b0;
         for (int i = 0; i < MAX_DIGITS; i++) begin
            secret_buf[i] <= 4'd0;
            guess_buf[i]  <= 4'd0;
         end
      end else begin
         keys_q  <= keys;
         enter_q <= enter;
         case (state)
            SECRET: begin
               if (enter_ok) begin
                  secret_len  <= digit_cnt_q;
                  digit_cnt_q <= '0;
               end else if (digit_ok) begin
                  secret_buf[digit_cnt_q] <= key_value;
                  digit_cnt_q             <= digit_cnt_q + CNT_W'(1);
                  nums_q                  <= key_press;
               end
            end
            GUESS: begin
               if (enter_ok) begin
                  equal_q   <= !cmp_gt && !cmp_lt;
                  bigger_q  <= cmp_gt;
                  smaller_q <= cmp_lt;
                  if (cmp_gt || cmp_lt) begin
                     tries_q     <= tries_q - 4'd1;
                     digit_cnt_q <= '0;
                     for (int i = 0; i < MAX_DIGITS; i++) begin
                        guess_buf[i] <= 4'd0;
                     end
                  end
               end else if (digit_ok) begin
                  guess_buf[digit_cnt_q] <= key_value;
                  digit_cnt_q            <= digit_cnt_q + CNT_W'(1);
                  nums_q                 <= key_press;
               end
            end
            default: begin
               // Any enter press after the game ends starts a fresh game.
               if (enter_press) begin
                  secret_len  <= '0;
                  digit_cnt_q <= '0;
                  tries_q     <= 4'(MAX_TRIES);
                  nums_q      <= '0;
                  equal_q     <= 1'b0;
                  bigger_q    <= 1'b0;
                  smaller_q   <= 1'b0;
                  for (int i = 0; i < MAX_DIGITS; i++) begin
                     secret_buf[i] <= 4'd0;
                     guess_buf[i]  <= 4'd0;
                  end
               end
            end
         endcase
      end
   end

endmodule
